// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester ports, the RAM drive and the ownership status of
// the data-memory arbiter into one interface.
//   slave  : the arbiter side (takes requests, drives RAM and responses)
//   master : the requester/RAM side (drives requests, sees grants/responses)
// Signals per requester n in {0,1}:
//   req<n>_valid_i/ready_o/we_i/addr_i/wdata_i/lock_i : request handshake
//   rsp<n>_valid_o/rdata_o                             : registered read reply
// RAM: mem_we_o, mem_a_o, mem_wd_o (to RAM), mem_rd_i (combinational from RAM)
// Status: owner_o (00 none, 01 port 0 owns, 10 port 1 owns)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          req0_valid_i;
    logic          req0_ready_o;
    logic          req0_we_i;
    logic [AW-1:0] req0_addr_i;
    logic [DW-1:0] req0_wdata_i;
    logic          req0_lock_i;
    logic          rsp0_valid_o;
    logic [DW-1:0] rsp0_rdata_o;

    logic          req1_valid_i;
    logic          req1_ready_o;
    logic          req1_we_i;
    logic [AW-1:0] req1_addr_i;
    logic [DW-1:0] req1_wdata_i;
    logic          req1_lock_i;
    logic          rsp1_valid_o;
    logic [DW-1:0] rsp1_rdata_o;

    logic          mem_we_o;
    logic [AW-1:0] mem_a_o;
    logic [DW-1:0] mem_wd_o;
    logic [DW-1:0] mem_rd_i;
    logic [1:0]    owner_o;

    modport slave (
        input  req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i, req0_lock_i,
        input  req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i, req1_lock_i,
        input  mem_rd_i,
        output req0_ready_o, rsp0_valid_o, rsp0_rdata_o,
        output req1_ready_o, rsp1_valid_o, rsp1_rdata_o,
        output mem_we_o, mem_a_o, mem_wd_o, owner_o
    );

    modport master (
        output req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i, req0_lock_i,
        output req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i, req1_lock_i,
        output mem_rd_i,
        input  req0_ready_o, rsp0_valid_o, rsp0_rdata_o,
        input  req1_ready_o, rsp1_valid_o, rsp1_rdata_o,
        input  mem_we_o, mem_a_o, mem_wd_o, owner_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data RAM between the CPU load/store path (port 0) and
// a debug/loader master (port 1). Grants are combinational (zero-cycle),
// read data is registered one cycle after acceptance. A requester may hold
// ownership across beats with lock_i; the burst is cut after MAX_BURST beats.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : dmem_arbiter_if.slave (requests, responses, RAM drive, owner_o)
// Parameters: DW data width, AW address width, MAX_BURST beats per lock (>=2)
// Build option: DMEM_ARB_RR_EN defined -> round-robin between contending
// ports in IDLE; undefined -> port 0 has fixed priority.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int            CW      = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CW-1:0] beat_inc;
    logic          grant0, grant1;
    logic          lock_g;
    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;
`ifdef DMEM_ARB_RR_EN
    logic          last_q, last_d;
`endif

    // Grant selection. rst is active low, so grants exist only while it is 1;
    // this keeps readies and mem_we low for the whole reset interval,
    // including a cycle in which reset asserts mid-cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req0_valid_i && bus.req1_valid_i) begin
`ifdef DMEM_ARB_RR_EN
                        // Favour the port that was not granted most recently.
                        grant0 = last_q;
                        grant1 = ~last_q;
`else
                        grant0 = 1'b1;
`endif
                    end else begin
                        grant0 = bus.req0_valid_i;
                        grant1 = bus.req1_valid_i;
                    end
                end
                OWN0:    grant0 = bus.req0_valid_i;
                OWN1:    grant1 = bus.req1_valid_i;
                default: ;
            endcase
        end
    end

    // Next state / burst counter.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        beat_inc   = beat_cnt_q + CW'(1);
        lock_g     = grant1 ? bus.req1_lock_i : bus.req0_lock_i;
        if (grant0 || grant1) begin
            if (lock_g && (beat_inc < MAX_CNT)) begin
                state_d    = grant1 ? OWN1 : OWN0;
                beat_cnt_d = beat_inc;
            end else begin
                // Lock dropped or burst limit hit: release with no bubble.
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        end else if (state_q != IDLE) begin
            // Owner stopped presenting beats: release, costing one idle cycle.
            state_d    = IDLE;
            beat_cnt_d = '0;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if (grant1) begin
            last_d = 1'b1;
        end else if (grant0) begin
            last_d = 1'b0;
        end
    end
`endif

    // Read responses: capture RAM data on an accepted read, hold otherwise.
    always_comb begin
        rsp0_valid_d = grant0 && !bus.req0_we_i;
        rsp1_valid_d = grant1 && !bus.req1_we_i;
        rsp0_rdata_d = rsp0_valid_d ? bus.mem_rd_i : rsp0_rdata_q;
        rsp1_rdata_d = rsp1_valid_d ? bus.mem_rd_i : rsp1_rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // last resets to 1 so that port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // With no grant the RAM address/data default to port 0's values.
    assign bus.mem_a_o      = grant1 ? bus.req1_addr_i  : bus.req0_addr_i;
    assign bus.mem_wd_o     = grant1 ? bus.req1_wdata_i : bus.req0_wdata_i;
    assign bus.mem_we_o     = (grant0 && bus.req0_we_i) || (grant1 && bus.req1_we_i);
    assign bus.req0_ready_o = grant0;
    assign bus.req1_ready_o = grant1;
    assign bus.rsp0_valid_o = rsp0_valid_q;
    assign bus.rsp1_valid_o = rsp1_valid_q;
    assign bus.rsp0_rdata_o = rsp0_rdata_q;
    assign bus.rsp1_rdata_o = rsp1_rdata_q;
    // State encoding matches the owner_o code directly.
    assign bus.owner_o      = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small RAM model and a response
// scoreboard. Expected read responses are queued when a read is driven that
// should be accepted and are compared when rsp*_valid_o pulses.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int MAX_BURST = 4;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    dmem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: combinational read, write on rising edge, loaded in reset.
    logic [31:0] ram [0:63];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++)
                ram[i] <= (i == 4) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));
        end else if (bus.mem_we_o) begin
            ram[bus.mem_a_o[7:2]] <= bus.mem_wd_o;
        end
    end
    assign bus.mem_rd_i = ram[bus.mem_a_o[7:2]];

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic r0, input logic r1,
                             input logic [1:0] own);
        chk({tag, "_ready0"}, 64'(bus.req0_ready_o), 64'(r0));
        chk({tag, "_ready1"}, 64'(bus.req1_ready_o), 64'(r1));
        chk({tag, "_owner"},  64'(bus.owner_o),      64'(own));
    endtask

    task automatic set0(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic lk);
        bus.req0_valid_i = v;
        bus.req0_we_i    = we;
        bus.req0_addr_i  = a;
        bus.req0_wdata_i = d;
        bus.req0_lock_i  = lk;
    endtask

    task automatic set1(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic lk);
        bus.req1_valid_i = v;
        bus.req1_we_i    = we;
        bus.req1_addr_i  = a;
        bus.req1_wdata_i = d;
        bus.req1_lock_i  = lk;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        sb.push_back(e);
    endtask

    // Response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp0_valid_o === 1'b1 && bus.rsp1_valid_o === 1'b1)
            chk("rsp_both_ports", 64'd1, 64'd0);
        if (bus.rsp0_valid_o === 1'b1 || bus.rsp1_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", (bus.rsp1_valid_o === 1'b1) ? 64'd1 : 64'd0, 64'(e.port));
                chk("rsp_data", (bus.rsp1_valid_o === 1'b1) ? 64'(bus.rsp1_rdata_o)
                                                           : 64'(bus.rsp0_rdata_o),
                    64'(e.data));
            end
        end
    end

    initial begin
        set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset: valid requests must not be granted while rst is low.
        #1 rst = 1'b0;
        #1;
        set0(1'b1, 1'b1, 32'h10, 32'h1, 1'b0);
        set1(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
        #1;
        chk_grant("reset", 1'b0, 1'b0, 2'b00);
        chk("reset_mem_we",  64'(bus.mem_we_o),     64'd0);
        chk("reset_rsp0_v",  64'(bus.rsp0_valid_o), 64'd0);
        chk("reset_rsp1_v",  64'(bus.rsp1_valid_o), 64'd0);
        chk("reset_rsp0_d",  64'(bus.rsp0_rdata_o), 64'd0);
        chk("reset_rsp1_d",  64'(bus.rsp1_rdata_o), 64'd0);
        tick;
        tick;
        set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;

        // Single read from port 0.
        tick;
        set0(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        #1;
        chk_grant("rd0", 1'b1, 1'b0, 2'b00);
        chk("rd0_mem_a",  64'(bus.mem_a_o),  64'h10);
        chk("rd0_mem_we", 64'(bus.mem_we_o), 64'd0);
        push(0, 32'hDEAD_BEEF);
        tick;
        set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rd0_rsp_valid", 64'(bus.rsp0_valid_o), 64'd1);

        // Write from port 1, then read it back.
        tick;
        set1(1'b1, 1'b1, 32'h40, 32'hCAFE_0001, 1'b0);
        #1;
        chk_grant("wr1", 1'b0, 1'b1, 2'b00);
        chk("wr1_mem_we", 64'(bus.mem_we_o), 64'd1);
        chk("wr1_mem_a",  64'(bus.mem_a_o),  64'h40);
        chk("wr1_mem_wd", 64'(bus.mem_wd_o), 64'hCAFE_0001);
        tick;
        set1(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        #1;
        chk_grant("rb1", 1'b0, 1'b1, 2'b00);
        chk("wr1_no_rsp",   64'(bus.rsp1_valid_o), 64'd0);
        chk("rsp0_hold_v",  64'(bus.rsp0_valid_o), 64'd0);
        chk("rsp0_hold_d",  64'(bus.rsp0_rdata_o), 64'hDEAD_BEEF);
        push(1, 32'hCAFE_0001);
        tick;
        set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Contention, no lock, four cycles (last grant was port 1).
        tick;
        set0(1'b1, 1'b0, 32'h00, 32'h0, 1'b0);
        set1(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (RR && (k % 2 == 1)) begin
                chk_grant($sformatf("cont%0d", k), 1'b0, 1'b1, 2'b00);
                push(1, 32'hA000_0001);
            end else begin
                chk_grant($sformatf("cont%0d", k), 1'b1, 1'b0, 2'b00);
                push(0, 32'hA000_0000);
            end
            tick;
        end
        set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Locked burst from port 1, cut after MAX_BURST beats.
        tick;
        set1(1'b1, 1'b1, 32'h20, 32'hB000_0000, 1'b1);
        #1;
        chk_grant("bst1", 1'b0, 1'b1, 2'b00);
        chk("bst1_mem_we", 64'(bus.mem_we_o), 64'd1);
        chk("bst1_mem_a",  64'(bus.mem_a_o),  64'h20);
        tick;
        set0(1'b1, 1'b0, 32'h08, 32'h0, 1'b0);
        set1(1'b1, 1'b1, 32'h24, 32'hB000_0001, 1'b1);
        #1;
        chk_grant("bst2", 1'b0, 1'b1, 2'b10);
        tick;
        set1(1'b1, 1'b1, 32'h28, 32'hB000_0002, 1'b1);
        #1;
        chk_grant("bst3", 1'b0, 1'b1, 2'b10);
        tick;
        set1(1'b1, 1'b1, 32'h2C, 32'hB000_0003, 1'b1);
        #1;
        chk_grant("bst4", 1'b0, 1'b1, 2'b10);
        chk("bst4_mem_wd", 64'(bus.mem_wd_o), 64'hB000_0003);
        tick;
        set1(1'b1, 1'b1, 32'h30, 32'hB000_0004, 1'b1);
        #1;
        chk_grant("bst_p0", 1'b1, 1'b0, 2'b00);
        chk("bst_p0_we", 64'(bus.mem_we_o), 64'd0);
        push(0, 32'hA000_0002);
        tick;
        set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk_grant("bst5", 1'b0, 1'b1, 2'b00);
        tick;
        set1(1'b1, 1'b1, 32'h34, 32'hB000_0005, 1'b1);
        #1;
        chk_grant("bst6", 1'b0, 1'b1, 2'b10);
        tick;
        set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk_grant("bst_drop", 1'b0, 1'b0, 2'b10);
        tick;
        set0(1'b1, 1'b0, 32'h2C, 32'h0, 1'b0);
        #1;
        chk_grant("bst_rb", 1'b1, 1'b0, 2'b00);
        push(0, 32'hB000_0003);
        tick;
        set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Lock dropped by deasserting valid: one bubble, then port 1.
        tick;
        set0(1'b1, 1'b0, 32'h00, 32'h0, 1'b1);
        #1;
        chk_grant("lk", 1'b1, 1'b0, 2'b00);
        push(0, 32'hA000_0000);
        tick;
        set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set1(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
        #1;
        chk_grant("lk_bubble", 1'b0, 1'b0, 2'b01);
        chk("lk_bubble_we", 64'(bus.mem_we_o), 64'd0);
        tick;
        #1;
        chk_grant("lk_p1", 1'b0, 1'b1, 2'b00);
        push(1, 32'hA000_0001);
        tick;
        set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset asserted in the middle of a port 0 locked burst.
        tick;
        set0(1'b1, 1'b1, 32'h50, 32'hC000_0000, 1'b1);
        #1;
        chk_grant("rs_b1", 1'b1, 1'b0, 2'b00);
        tick;
        set0(1'b1, 1'b1, 32'h54, 32'hC000_0001, 1'b1);
        #1;
        chk_grant("rs_b2", 1'b1, 1'b0, 2'b01);
        tick;
        set0(1'b1, 1'b1, 32'h58, 32'hC000_0002, 1'b1);
        set1(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
        #1;
        chk_grant("rs_pre", 1'b1, 1'b0, 2'b01);
        rst = 1'b0;
        #1;
        chk_grant("rs_in", 1'b0, 1'b0, 2'b00);
        chk("rs_in_mem_we", 64'(bus.mem_we_o),     64'd0);
        chk("rs_in_rsp0_d", 64'(bus.rsp0_rdata_o), 64'd0);
        chk("rs_in_rsp1_d", 64'(bus.rsp1_rdata_o), 64'd0);
        tick;
        rst = 1'b1;
        set0(1'b1, 1'b0, 32'h00, 32'h0, 1'b0);
        set1(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
        #1;
        chk_grant("rs_after", 1'b1, 1'b0, 2'b00);
        push(0, 32'hA000_0000);
        tick;
        #1;
        if (RR) begin
            chk_grant("rs_next", 1'b0, 1'b1, 2'b00);
            push(1, 32'hA000_0001);
        end else begin
            chk_grant("rs_next", 1'b1, 1'b0, 2'b00);
            push(0, 32'hA000_0000);
        end
        tick;
        set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        tick;
        tick;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
